// File: rtl/sram_pkg.sv
// Shared types and constants for the register-file SRAM request controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_EN,
        RD_CAP,
        RESP,
        CLEAR
    } state_t;

    localparam int unsigned DEF_WORDS = 16;
    localparam int unsigned DEF_AW    = 4;
    localparam int unsigned DEF_DW    = 4;

    // Idle levels of the array controls: strobes/selects are active-low.
    localparam logic EN_OFF   = 1'b1;
    localparam logic BUS_HIZ  = 1'b1;
    localparam logic CLR_IDLE = 1'b0;

endpackage

// File: rtl/sram_addr_dec.sv
// Active-low one-hot word decoder; addresses at or above WORDS select nothing.
module sram_addr_dec #(
    parameter int unsigned WORDS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    output logic [WORDS-1:0] o_sel_n
);

    always_comb begin
        o_sel_n = '1;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (i_en && (32'(i_addr) == i)) begin
                o_sel_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Request-side controller for the d_register word array: single read/write
// and clear-all sequencing behind a valid/ready handshake, all outputs registered.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned WORDS = DEF_WORDS,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_clr,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    output logic [DW-1:0]    arr_D,
    output logic             arr_G1_n,
    output logic [WORDS-1:0] arr_G2_n,
    output logic [WORDS-1:0] arr_M,
    output logic             arr_N,
    output logic             arr_CLR,
    input  logic [DW-1:0]    arr_Q
);

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_idx;
    logic [4:0]       w_next_idx;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_ready;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rdata;
    logic             r_g1_n;
    logic [WORDS-1:0] r_g2_n;
    logic [WORDS-1:0] r_m;
    logic             r_n;
    logic             r_clr;

    logic             w_accept;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_g1_n;
    logic [AW-1:0]    w_dec_addr;
    logic [WORDS-1:0] w_g2_n;
    logic [WORDS-1:0] w_m_n;
    logic             w_oor;

    assign w_accept = (r_state == IDLE) && r_ready && req_valid;
    assign w_oor    = (32'(r_addr) >= WORDS);

    // Enables are computed for the state being entered so the registered
    // outputs line up with the cycle that state occupies.
    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        w_dec_addr = r_addr;
        w_wr_en    = 1'b0;
        w_rd_en    = 1'b0;
        w_g1_n     = EN_OFF;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_idx = '0;
                    if (req_clr) begin
                        w_next     = CLEAR;
                        w_dec_addr = '0;
                        w_wr_en    = 1'b1;
                        w_g1_n     = ~EN_OFF;
                    end else if (req_we) begin
                        w_next     = WRITE;
                        w_dec_addr = req_addr;
                        w_wr_en    = 1'b1;
                        w_g1_n     = ~EN_OFF;
                    end else begin
                        w_next     = RD_EN;
                        w_dec_addr = req_addr;
                        w_rd_en    = 1'b1;
                    end
                end
            end
            WRITE:  w_next = IDLE;
            RD_EN: begin
                w_next  = RD_CAP;
                w_rd_en = 1'b1;
            end
            RD_CAP: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            CLEAR: begin
                if (32'(r_idx) == WORDS - 1) begin
                    w_next = IDLE;
                end else begin
                    w_next_idx = r_idx + 5'd1;
                    w_dec_addr = AW'(w_next_idx);
                    w_wr_en    = 1'b1;
                    w_g1_n     = ~EN_OFF;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    sram_addr_dec #(.WORDS(WORDS), .AW(AW)) u_dec_wr (
        .i_en    (w_wr_en),
        .i_addr  (w_dec_addr),
        .o_sel_n (w_g2_n)
    );

    sram_addr_dec #(.WORDS(WORDS), .AW(AW)) u_dec_rd (
        .i_en    (w_rd_en),
        .i_addr  (w_dec_addr),
        .o_sel_n (w_m_n)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_g1_n      <= EN_OFF;
            r_g2_n      <= {WORDS{EN_OFF}};
            r_m         <= {WORDS{EN_OFF}};
            r_n         <= BUS_HIZ;
            r_clr       <= ~CLR_IDLE;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_next_idx;
            r_ready     <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            r_g1_n      <= w_g1_n;
            r_g2_n      <= w_g2_n;
            r_m         <= w_m_n;
            r_n         <= ~w_rd_en;
            r_clr       <= CLR_IDLE;
            if (w_accept) begin
                r_addr  <= req_clr ? '0 : req_addr;
                r_wdata <= (req_clr || !req_we) ? '0 : req_wdata;
            end
            if (r_state == RD_CAP) begin
                r_rdata <= w_oor ? '0 : arr_Q;
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign arr_D     = r_wdata;
    assign arr_G1_n  = r_g1_n;
    assign arr_G2_n  = r_g2_n;
    assign arr_M     = r_m;
    assign arr_N     = r_n;
    assign arr_CLR   = r_clr;

endmodule
